// File: rtl/bus_slave_if.sv
// bus_slave_if: 4-phase IO bus between the bridge master and a register slave.
//   handshake_1  master -> slave  request; rw/reg_address/data_out valid while high
//   handshake_2  slave -> master  acknowledge
//   rw           master -> slave  1 = read, 0 = write
//   reg_address  master -> slave  global 8-bit register address
//   data_out     master -> slave  write data
//   data_in      slave -> master  read data, 0 when the slave is not selected
interface bus_slave_if;
    logic        handshake_1;
    logic        handshake_2;
    logic        rw;
    logic [7:0]  reg_address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    modport master(output handshake_1, rw, reg_address, data_out, input handshake_2, data_in);
    modport slave(input handshake_1, rw, reg_address, data_out, output handshake_2, data_in);
endinterface

// File: rtl/bus_slave_regs.sv
// bus_slave_regs: register-bank responder on the 4-phase IO bus.
//   clk               system clock, rising edge
//   reset             synchronous, active-low
//   bus               slave side of bus_slave_if
//   config_regs       flattened R/W config registers, reg k at [32k+31:32k]
//   reg_write_strobe  one-cycle pulse, bit k on a completed write to reg k
//   status_in         live subsystem status, read at index NOS_REGS-1
//   slave_busy        high whenever the FSM is not idle
module bus_slave_regs #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         NOS_REGS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    bus_slave_if.slave                    bus,
    output logic [32*(NOS_REGS-1)-1:0]    config_regs,
    output logic [NOS_REGS-2:0]           reg_write_strobe,
    input  logic [31:0]                   status_in,
    output logic                          slave_busy
);
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACK} state_t;
    localparam logic [3:0] STATUS_IDX = 4'(NOS_REGS - 1);
    state_t                       state_q, state_d;
    logic                         rw_q, rw_d;
    logic [3:0]                   idx_q, idx_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic                         hs2_q, hs2_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [NOS_REGS-2:0][31:0]    cfg_q, cfg_d;
    logic [NOS_REGS-2:0]          strobe_q, strobe_d;
    logic                         err_q, err_d;
    logic [8:0]                   addr_ext;
    logic                         hit;
    logic [3:0]                   index;
    // 9-bit compare so BASE_ADDR+NOS_REGS cannot wrap past 255
    assign addr_ext = {1'b0, bus.reg_address};
    assign hit      = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < {1'b0, BASE_ADDR} + 9'(NOS_REGS));
    // low nibble of the 8-bit difference equals the difference of the low nibbles
    assign index    = bus.reg_address[3:0] - BASE_ADDR[3:0];
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        hs2_d    = hs2_q;
        rdata_d  = rdata_q;
        cfg_d    = cfg_q;
        strobe_d = '0;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.handshake_1 && hit) begin
                    rw_d    = bus.rw;
                    idx_d   = index;
                    wdata_d = bus.data_out;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!bus.handshake_1) begin
                    state_d = S_IDLE;
                end else begin
                    hs2_d   = 1'b1;
                    state_d = S_ACK;
                    if (rw_q) begin
                        // status read reports and clears the write-to-status error
                        rdata_d = {status_in[31:1], err_q};
                        for (int k = 0; k < NOS_REGS - 1; k++)
                            if (idx_q == 4'(k)) rdata_d = cfg_q[k];
                        if (idx_q == STATUS_IDX) err_d = 1'b0;
                    end else if (idx_q == STATUS_IDX) begin
                        err_d = 1'b1;
                    end else begin
                        for (int k = 0; k < NOS_REGS - 1; k++)
                            if (idx_q == 4'(k)) begin
                                cfg_d[k]    = wdata_q;
                                strobe_d[k] = 1'b1;
                            end
                    end
                end
            end
            S_ACK: begin
                if (!bus.handshake_1) begin
                    hs2_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rw_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            hs2_q    <= 1'b0;
            rdata_q  <= '0;
            cfg_q    <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            hs2_q    <= hs2_d;
            rdata_q  <= rdata_d;
            cfg_q    <= cfg_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end
    assign bus.handshake_2    = hs2_q;
    assign bus.data_in        = rdata_q;
    assign config_regs        = cfg_q;
    assign reg_write_strobe   = strobe_q;
    assign slave_busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_bus_slave_regs.sv
// tb_bus_slave_regs: directed bench for bus_slave_regs with BASE_ADDR=8, NOS_REGS=4.
module tb_bus_slave_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] status_in = '0;
    logic [95:0] config_regs;
    logic [2:0]  reg_write_strobe;
    logic        slave_busy;
    int          total = 0;
    int          bad = 0;
    bus_slave_if bus();
    bus_slave_regs #(.BASE_ADDR(8'd8), .NOS_REGS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .config_regs      (config_regs),
        .reg_write_strobe (reg_write_strobe),
        .status_in        (status_in),
        .slave_busy       (slave_busy)
    );
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: runs one full 4-phase transaction and reports what it saw.
    task automatic xfer(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic ok, output logic [2:0] strb);
        logic acked;
        acked = 1'b0;
        rd = '0;
        strb = '0;
        bus.rw = rw;
        bus.reg_address = a;
        bus.data_out = d;
        bus.handshake_1 = 1'b1;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            strb |= reg_write_strobe;
            if (bus.handshake_2) begin
                acked = 1'b1;
                rd = bus.data_in;
            end
        end
        bus.handshake_1 = 1'b0;
        tick();
        strb |= reg_write_strobe;
        ok = acked && !bus.handshake_2 && (bus.data_in == 32'h0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.rw = 1'b0;
        bus.reg_address = 8'd8;
        bus.data_out = 32'h1;
        bus.handshake_1 = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.handshake_2, slave_busy, reg_write_strobe} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got hs2=%b busy=%b strb=%b want 0", bus.handshake_2, slave_busy, reg_write_strobe);
        end
        total++;
        if (bus.data_in !== 32'h0 || config_regs !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got din=%h cfg=%h want 0", bus.data_in, config_regs);
        end
        bus.handshake_1 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        logic [31:0] rd;
        logic        ok;
        logic [2:0]  strb;
        bus.rw = 1'b0;
        bus.reg_address = 8'd9;
        bus.data_out = 32'hDEADBEEF;
        bus.handshake_1 = 1'b1;
        tick();
        total++;
        if (bus.handshake_2 !== 1'b0 || slave_busy !== 1'b1) begin
            bad++;
            $display("FAIL t1_edge1 got hs2=%b busy=%b want 0/1", bus.handshake_2, slave_busy);
        end
        tick();
        total++;
        if (bus.handshake_2 !== 1'b1 || config_regs[63:32] !== 32'hDEADBEEF || reg_write_strobe !== 3'b010) begin
            bad++;
            $display("FAIL t1_edge2 got hs2=%b reg1=%h strb=%b want 1/deadbeef/010", bus.handshake_2, config_regs[63:32], reg_write_strobe);
        end
        bus.handshake_1 = 1'b0;
        tick();
        total++;
        if (bus.handshake_2 !== 1'b0 || reg_write_strobe !== 3'b000 || slave_busy !== 1'b0) begin
            bad++;
            $display("FAIL t1_release got hs2=%b strb=%b busy=%b want 0", bus.handshake_2, reg_write_strobe, slave_busy);
        end
        xfer(1'b1, 8'd9, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL t1_readback got ok=%b rd=%h want 1/deadbeef", ok, rd);
        end
    endtask

    task automatic test_status_read;
        logic [31:0] rd;
        logic        ok;
        logic [2:0]  strb;
        status_in = 32'h12345679;
        xfer(1'b1, 8'd11, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h12345678) begin
            bad++;
            $display("FAIL t2_status got ok=%b rd=%h want 1/12345678", ok, rd);
        end
    endtask

    task automatic test_status_write_err;
        logic [31:0] rd;
        logic        ok;
        logic [2:0]  strb;
        xfer(1'b0, 8'd11, 32'hFFFFFFFF, rd, ok, strb);
        total++;
        if (!ok || strb !== 3'b000 || config_regs !== {32'h0, 32'hDEADBEEF, 32'h0}) begin
            bad++;
            $display("FAIL t3_write got ok=%b strb=%b cfg=%h want 1/000/0_deadbeef_0", ok, strb, config_regs);
        end
        xfer(1'b1, 8'd11, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h12345679) begin
            bad++;
            $display("FAIL t3_err_set got ok=%b rd=%h want 1/12345679", ok, rd);
        end
        xfer(1'b1, 8'd11, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h12345678) begin
            bad++;
            $display("FAIL t3_err_clear got ok=%b rd=%h want 1/12345678", ok, rd);
        end
    endtask

    task automatic test_no_hit;
        logic [7:0] addrs [2];
        logic       seen;
        addrs[0] = 8'd7;
        addrs[1] = 8'd12;
        for (int j = 0; j < 2; j++) begin
            seen = 1'b0;
            bus.rw = 1'b1;
            bus.reg_address = addrs[j];
            bus.data_out = 32'h0;
            bus.handshake_1 = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                seen |= bus.handshake_2 | (bus.data_in != 32'h0) | slave_busy;
            end
            bus.handshake_1 = 1'b0;
            tick();
            total++;
            if (seen !== 1'b0) begin
                bad++;
                $display("FAIL t4_nohit addr=%0d got activity=%b want 0", addrs[j], seen);
            end
        end
    endtask

    task automatic test_abort;
        logic seen;
        bus.rw = 1'b0;
        bus.reg_address = 8'd8;
        bus.data_out = 32'h55AA55AA;
        bus.handshake_1 = 1'b1;
        tick();
        total++;
        if (slave_busy !== 1'b1) begin
            bad++;
            $display("FAIL t5_busy got %b want 1", slave_busy);
        end
        bus.handshake_1 = 1'b0;
        seen = 1'b0;
        tick();
        total++;
        if (slave_busy !== 1'b0) begin
            bad++;
            $display("FAIL t5_idle got busy=%b want 0", slave_busy);
        end
        for (int i = 0; i < 3; i++) begin
            seen |= bus.handshake_2 | (reg_write_strobe != 3'b0);
            tick();
        end
        total++;
        if (seen !== 1'b0 || config_regs[31:0] !== 32'h0) begin
            bad++;
            $display("FAIL t5_abort got act=%b reg0=%h want 0/0", seen, config_regs[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        ok;
        logic [2:0]  strb;
        xfer(1'b0, 8'd8, 32'h11111111, rd, ok, strb);
        total++;
        if (!ok || strb !== 3'b001) begin
            bad++;
            $display("FAIL b2b_w0 got ok=%b strb=%b want 1/001", ok, strb);
        end
        xfer(1'b0, 8'd10, 32'hA5A5A5A5, rd, ok, strb);
        total++;
        if (!ok || strb !== 3'b100) begin
            bad++;
            $display("FAIL b2b_w2 got ok=%b strb=%b want 1/100", ok, strb);
        end
        total++;
        if (config_regs !== {32'hA5A5A5A5, 32'hDEADBEEF, 32'h11111111}) begin
            bad++;
            $display("FAIL b2b_cfg got %h want a5a5a5a5_deadbeef_11111111", config_regs);
        end
        xfer(1'b1, 8'd8, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h11111111) begin
            bad++;
            $display("FAIL b2b_r0 got ok=%b rd=%h want 1/11111111", ok, rd);
        end
        xfer(1'b1, 8'd10, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL b2b_r2 got ok=%b rd=%h want 1/a5a5a5a5", ok, rd);
        end
    endtask

    task automatic test_reset_in_ack;
        logic [31:0] rd;
        logic        ok;
        logic [2:0]  strb;
        bus.rw = 1'b1;
        bus.reg_address = 8'd9;
        bus.data_out = 32'h0;
        bus.handshake_1 = 1'b1;
        tick();
        tick();
        total++;
        if (bus.handshake_2 !== 1'b1 || bus.data_in !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL t6_in_ack got hs2=%b din=%h want 1/deadbeef", bus.handshake_2, bus.data_in);
        end
        reset = 1'b0;
        bus.handshake_1 = 1'b0;
        tick();
        total++;
        if ({bus.handshake_2, slave_busy, reg_write_strobe} !== 5'b0 || bus.data_in !== 32'h0 || config_regs !== 96'h0) begin
            bad++;
            $display("FAIL t6_reset got hs2=%b busy=%b strb=%b din=%h cfg=%h want 0", bus.handshake_2, slave_busy, reg_write_strobe, bus.data_in, config_regs);
        end
        reset = 1'b1;
        tick();
        xfer(1'b1, 8'd8, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h0) begin
            bad++;
            $display("FAIL t6_read0 got ok=%b rd=%h want 1/0", ok, rd);
        end
        xfer(1'b1, 8'd9, 32'h0, rd, ok, strb);
        total++;
        if (!ok || rd !== 32'h0) begin
            bad++;
            $display("FAIL t6_read1 got ok=%b rd=%h want 1/0", ok, rd);
        end
    endtask

    initial begin
        bus.handshake_1 = 1'b0;
        bus.rw = 1'b0;
        bus.reg_address = 8'h0;
        bus.data_out = 32'h0;
        test_reset();
        test_write_read();
        test_status_read();
        test_status_write_err();
        test_no_hit();
        test_abort();
        test_back_to_back();
        test_reset_in_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
